// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/stop/lap/clear FSM, a BCD mm:ss.cc counter
// advanced by the 10 ms tick, a freezable display register, a sticky
// wrap flag and the run/phase-reset controls for the tick generator.
// Every output comes straight from a flop.
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59  // highest minute count, binary, 1..99
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iGEN_10MS,
  input  logic       iSTART_STOP,
  input  logic       iLAP_CLR,
  output logic       oCK_RUN,
  output logic       oCK_RST,
  output logic [7:0] oCSEC,
  output logic [7:0] oSEC,
  output logic [7:0] oMIN,
  output logic       oLAP_HOLD,
  output logic [1:0] oSTATE,
  output logic       oOVF
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_e;

  // MIN_MAX re-encoded as two BCD digits so it compares directly against
  // the minute counter.
  localparam logic [7:0] MIN_MAX_BCD = 8'(((MIN_MAX / 10) * 16) + (MIN_MAX % 10));

  // Increment a two-digit BCD value; the caller handles the wrap point.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cs_q, cs_d, sec_q, sec_d, min_q, min_d;
  logic [7:0] disp_cs_q, disp_cs_d, disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic       ovf_q, ovf_d;
  logic       ck_run_q, ck_run_d;
  logic       ck_rst_q, ck_rst_d;
  logic       lap_hold_q, lap_hold_d;

  // Start/stop wins a same-cycle collision, so lap/clear is masked by it.
  logic start_cmd, lap_cmd, clear_evt, counting;
  assign start_cmd = iSTART_STOP;
  assign lap_cmd   = iLAP_CLR & ~iSTART_STOP;
  assign clear_evt = (state_q == STOP) && lap_cmd;
  // Gated on the registered state: a tick alongside a stop is still counted.
  assign counting  = iGEN_10MS && ((state_q == RUN) || (state_q == LAP));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the order of statements in this block does not matter.
    if (iRESET) begin
      state_q    <= IDLE;
      cs_q       <= 8'h00;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      disp_cs_q  <= 8'h00;
      disp_sec_q <= 8'h00;
      disp_min_q <= 8'h00;
      ovf_q      <= 1'b0;
      ck_run_q   <= 1'b0;
      ck_rst_q   <= 1'b1;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      disp_cs_q  <= disp_cs_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
      ovf_q      <= ovf_d;
      ck_run_q   <= ck_run_d;
      ck_rst_q   <= ck_rst_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  // Next-state logic for the run/stop/lap/clear FSM.
  always_comb begin
    // NOTE: assigning a default before the case means no path leaves state_d
    // unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_cmd) state_d = RUN;
      RUN:  if (start_cmd) state_d = STOP; else if (lap_cmd) state_d = LAP;
      LAP:  if (start_cmd) state_d = STOP; else if (lap_cmd) state_d = RUN;
      STOP: if (start_cmd) state_d = RUN;  else if (lap_cmd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the flops present them
  // in the same cycle the state code changes.
  always_comb begin
    ck_run_d   = (state_d == RUN) || (state_d == LAP);
    ck_rst_d   = clear_evt;
    lap_hold_d = (state_d == LAP);
  end

  // Live BCD counter, wrap flag and display register.
  always_comb begin
    cs_d       = cs_q;
    sec_d      = sec_q;
    min_d      = min_q;
    ovf_d      = ovf_q;
    disp_cs_d  = disp_cs_q;
    disp_sec_d = disp_sec_q;
    disp_min_d = disp_min_q;

    if (clear_evt) begin
      cs_d  = 8'h00;
      sec_d = 8'h00;
      min_d = 8'h00;
      ovf_d = 1'b0;
    end else if (counting) begin
      if (cs_q == 8'h99) begin
        cs_d = 8'h00;
        if (sec_q == 8'h59) begin
          sec_d = 8'h00;
          if (min_q == MIN_MAX_BCD) begin
            min_d = 8'h00;
            ovf_d = 1'b1;
          end else begin
            min_d = bcd_inc(min_q);
          end
        end else begin
          sec_d = bcd_inc(sec_q);
        end
      end else begin
        cs_d = bcd_inc(cs_q);
      end
    end

    // The display tracks the live counter except while staying in LAP; the
    // entry edge still loads (capturing the entry-cycle value) and the exit
    // edge loads so the display is live again on the following cycle.
    if (!((state_q == LAP) && (state_d == LAP))) begin
      disp_cs_d  = cs_d;
      disp_sec_d = sec_d;
      disp_min_d = min_d;
    end
  end

  assign oCK_RUN   = ck_run_q;
  assign oCK_RST   = ck_rst_q;
  assign oCSEC     = disp_cs_q;
  assign oSEC      = disp_sec_q;
  assign oMIN      = disp_min_q;
  assign oLAP_HOLD = lap_hold_q;
  assign oSTATE    = state_q;
  assign oOVF      = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl. Stimulus applies directed command and
// tick patterns and pushes hand-computed expected outputs into a queue; a
// monitor on the falling edge pops each entry and compares it against the
// DUT. MIN_MAX is 10 so the minute wrap (and the 09->10 BCD carry) is
// reachable in a short run.
module tb_stopwatch_ctrl;

  localparam int MIN_MAX = 10;

  logic       iCLK = 1'b0;
  logic       iRESET = 1'b0;
  logic       iGEN_10MS = 1'b0;
  logic       iSTART_STOP = 1'b0;
  logic       iLAP_CLR = 1'b0;
  logic       oCK_RUN, oCK_RST, oLAP_HOLD, oOVF;
  logic [7:0] oCSEC, oSEC, oMIN;
  logic [1:0] oSTATE;

  stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iGEN_10MS(iGEN_10MS),
    .iSTART_STOP(iSTART_STOP), .iLAP_CLR(iLAP_CLR),
    .oCK_RUN(oCK_RUN), .oCK_RST(oCK_RST), .oCSEC(oCSEC), .oSEC(oSEC),
    .oMIN(oMIN), .oLAP_HOLD(oLAP_HOLD), .oSTATE(oSTATE), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string      name;
    logic [7:0] m, s, cs;
    logic [1:0] st;
    logic       run, rst, hold, ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  always @(negedge iCLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "min",   oMIN,  e.m);
      check(e.name, "sec",   oSEC,  e.s);
      check(e.name, "csec",  oCSEC, e.cs);
      check(e.name, "state", {6'd0, oSTATE},    {6'd0, e.st});
      check(e.name, "run",   {7'd0, oCK_RUN},   {7'd0, e.run});
      check(e.name, "rst",   {7'd0, oCK_RST},   {7'd0, e.rst});
      check(e.name, "hold",  {7'd0, oLAP_HOLD}, {7'd0, e.hold});
      check(e.name, "ovf",   {7'd0, oOVF},      {7'd0, e.ovf});
    end
  end

  task automatic expect_out(input string name, input logic [7:0] m, s, cs,
                            input logic [1:0] st, input logic run, rst, hold, ovf);
    exp_t e;
    e.name = name; e.m = m; e.s = s; e.cs = cs; e.st = st;
    e.run = run; e.rst = rst; e.hold = hold; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs; inputs change 1 time unit after the edge.
  task automatic step(input logic rs, ss, lc, tk);
    iRESET = rs; iSTART_STOP = ss; iLAP_CLR = lc; iGEN_10MS = tk;
    @(posedge iCLK);
    #1;
    iRESET = 1'b0; iSTART_STOP = 1'b0; iLAP_CLR = 1'b0; iGEN_10MS = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    // Reset state and first cycle after release.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("reset", 8'h00, 8'h00, 8'h00, 2'b00, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("post_reset", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0);

    // IDLE ignores lap/clear and ticks.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("idle_ignore", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0);

    // Basic run: 150 ticks.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("start", 8'h00, 8'h00, 8'h00, 2'b01, 1, 0, 0, 0);
    ticks(150);
    expect_out("run_150", 8'h00, 8'h01, 8'h50, 2'b01, 1, 0, 0, 0);

    // Stop, ticks ignored, then clear.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("stop", 8'h00, 8'h01, 8'h50, 2'b10, 0, 0, 0, 0);
    ticks(5);
    expect_out("stop_ticks", 8'h00, 8'h01, 8'h50, 2'b10, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("clear", 8'h00, 8'h00, 8'h00, 2'b00, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("clear_after", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0);

    // Lap: display freezes while counting continues.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(100);
    expect_out("lap_pre", 8'h00, 8'h01, 8'h00, 2'b01, 1, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("lap_enter", 8'h00, 8'h01, 8'h00, 2'b11, 1, 0, 1, 0);
    ticks(30);
    expect_out("lap_frozen", 8'h00, 8'h01, 8'h00, 2'b11, 1, 0, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("lap_exit", 8'h00, 8'h01, 8'h30, 2'b01, 1, 0, 0, 0);
    // LAP -> STOP on start/stop shows the live value.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("lap_to_stop", 8'h00, 8'h01, 8'h50, 2'b10, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Simultaneous start/stop + lap + tick at 00:00.10 in RUN.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    expect_out("sim_pre", 8'h00, 8'h00, 8'h10, 2'b01, 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    expect_out("simultaneous", 8'h00, 8'h00, 8'h11, 2'b10, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Held start/stop: one command per high cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("held_cmd", 8'h00, 8'h00, 8'h00, 2'b10, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-run reset overrides a concurrent tick and command.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(200);
    expect_out("rst_pre", 8'h00, 8'h02, 8'h00, 2'b01, 1, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("mid_reset", 8'h00, 8'h00, 8'h00, 2'b00, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("mid_reset_after", 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0);

    // Wrap at MIN_MAX:59.99, passing the 09 -> 10 minute carry.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(59999);
    expect_out("pre_min10", 8'h09, 8'h59, 8'h99, 2'b01, 1, 0, 0, 0);
    ticks(1);
    expect_out("min10", 8'h10, 8'h00, 8'h00, 2'b01, 1, 0, 0, 0);
    ticks(5999);
    expect_out("pre_wrap", 8'h10, 8'h59, 8'h99, 2'b01, 1, 0, 0, 0);
    ticks(1);
    expect_out("wrap", 8'h00, 8'h00, 8'h00, 2'b01, 1, 0, 0, 1);
    ticks(3);
    expect_out("ovf_sticky", 8'h00, 8'h00, 8'h03, 2'b01, 1, 0, 0, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("ovf_stop", 8'h00, 8'h00, 8'h03, 2'b10, 0, 0, 0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("ovf_clear", 8'h00, 8'h00, 8'h00, 2'b00, 0, 1, 0, 0);

    repeat (2) @(posedge iCLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
- REQ-001 SHALL have parameter MIN_MAX, default 59: highest minute count, binary, range 1..99.
- REQ-002 SHALL have port iCLK, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port iRESET, input, 1 bit: synchronous, active-high reset.
- REQ-004 SHALL have port iGEN_10MS, input, 1 bit: single-cycle 10 ms tick from the tick generator.
- REQ-005 SHALL have port iSTART_STOP, input, 1 bit: single-cycle start/stop command pulse.
- REQ-006 SHALL have port iLAP_CLR, input, 1 bit: single-cycle lap/clear command pulse.
- REQ-007 SHALL have port oCK_RUN, output, 1 bit: run enable to the tick generator.
- REQ-008 SHALL have port oCK_RST, output, 1 bit: phase-reset strobe to the tick generator.
- REQ-009 SHALL have port oCSEC, output, 8 bits: displayed centiseconds as 2-digit BCD, 00..99.
- REQ-010 SHALL have port oSEC, output, 8 bits: displayed seconds as 2-digit BCD, 00..59.
- REQ-011 SHALL have port oMIN, output, 8 bits: displayed minutes as 2-digit BCD, 00..MIN_MAX.
- REQ-012 SHALL have port oLAP_HOLD, output, 1 bit: high while the display is frozen.
- REQ-013 SHALL have port oSTATE, output, 2 bits: current FSM state code.
- REQ-014 SHALL have port oOVF, output, 1 bit: sticky wrap-around flag.

Function
- REQ-015 SHALL implement four states with these codes: IDLE=00, RUN=01, STOP=10, LAP=11.
- REQ-016 SHALL register every output; no output may have a combinational path from any input.
- REQ-017 SHALL give iSTART_STOP priority over iLAP_CLR when both are asserted in the same cycle; iLAP_CLR is then ignored.
- REQ-018 SHALL, in IDLE, move to RUN on iSTART_STOP and ignore iLAP_CLR.
- REQ-019 SHALL, in RUN, move to STOP on iSTART_STOP and to LAP on iLAP_CLR.
- REQ-020 SHALL, in LAP, move to STOP on iSTART_STOP and return to RUN on iLAP_CLR.
- REQ-021 SHALL, in STOP, move to RUN on iSTART_STOP and to IDLE on iLAP_CLR.
- REQ-022 SHALL, on the STOP->IDLE transition, clear the live counters, the display and oOVF, and drive oCK_RST high for exactly one cycle.
- REQ-023 SHALL drive oCK_RUN = 1 in RUN and LAP, and 0 in IDLE and STOP.
- REQ-024 SHALL advance the live counter on iGEN_10MS only when the registered (current) state is RUN or LAP; a tick arriving in the same cycle as a stop command is still counted.
- REQ-025 SHALL ignore iGEN_10MS in IDLE and STOP.
- REQ-026 SHALL count in BCD with this carry chain:
  - csec 99 -> 00, carry into sec;
  - sec 59 -> 00, carry into min;
  - min MIN_MAX -> 00.
- REQ-027 SHALL set oOVF on the tick that wraps MIN_MAX:59.99 to 00:00.00; oOVF holds until reset or the STOP->IDLE clear.
- REQ-028 SHALL update the display from the live counters one cycle after each count; counting latency from tick to output is 1 cycle.
- REQ-029 SHALL, in LAP, freeze the display at the live value from the cycle of entry, hold oLAP_HOLD = 1, and keep counting internally.
- REQ-030 SHALL, on leaving LAP, clear oLAP_HOLD and resume live display updates on the next cycle.
- REQ-031 SHALL treat command inputs held high for more than one cycle as one command per high cycle; rising-edge detection is the sender's job.

Reset
- REQ-032 SHALL, while iRESET = 1 at a rising iCLK edge, force:
  - state IDLE;
  - oCSEC, oSEC and oMIN = 00;
  - oCK_RUN, oLAP_HOLD and oOVF = 0;
  - oCK_RST = 1.
- REQ-033 SHALL, in the first cycle after iRESET deasserts, have oCK_RST = 0.
- REQ-034 SHALL let a mid-operation reset override all commands and ticks in that cycle.

Verification
- REQ-035 Basic run: reset, iSTART_STOP, then 150 ticks -> oMIN=00, oSEC=01, oCSEC=50, oCK_RUN=1, oSTATE=01.
- REQ-036 Stop/clear: from 00:01.50, iSTART_STOP then 5 ticks -> display unchanged, oCK_RUN=0; then iLAP_CLR -> one-cycle oCK_RST=1, display 00:00.00, oSTATE=00.
- REQ-037 Lap: run 100 ticks, iLAP_CLR, 30 ticks -> display 00:01.00, oLAP_HOLD=1; then iLAP_CLR -> display 00:01.30, oLAP_HOLD=0.
- REQ-038 Wrap: preload by ticking to 59:59.99, then one tick -> 00:00.00, oOVF=1; oOVF stays 1 through further ticks until the clear.
- REQ-039 Simultaneous: iSTART_STOP, iLAP_CLR and iGEN_10MS all asserted in RUN at 00:00.10 -> state STOP, display 00:00.11, not LAP.
- REQ-040 Mid-run reset: iRESET during RUN at 00:02.00 with a concurrent tick -> 00:00.00, IDLE, oCK_RST=1 for that cycle.
